// File: rtl/controller_mc_if.sv
// -----------------------------------------------------------------------------
// controller_mc_if
// Bundle between the multicycle controller and the RV32I datapath.
//   Datapath -> controller : opcode, funct3, funct7 (IR fields), zero_flag,
//                            alu_lt (ALU flags), mem_ready, resume
//   Controller -> datapath : adr_src, mem_req, mem_write, mem_ctrl, pc_write,
//                            ir_write, reg_write, out_mux_sel, load_extend_sel,
//                            imm_extend_sel, alu_src_a_sel, alu_src_b_sel,
//                            alu_ctrl, halted, trap, trap_cause, instret
// master = controller side, slave = datapath side.
// -----------------------------------------------------------------------------
interface controller_mc_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic             zero_flag;
  logic             alu_lt;
  logic             mem_ready;
  logic             resume;

  logic             adr_src;
  logic             mem_req;
  logic             mem_write;
  logic [1:0]       mem_ctrl;
  logic             pc_write;
  logic             ir_write;
  logic             reg_write;
  logic [1:0]       out_mux_sel;
  logic [2:0]       load_extend_sel;
  logic [2:0]       imm_extend_sel;
  logic [1:0]       alu_src_a_sel;
  logic [1:0]       alu_src_b_sel;
  logic [3:0]       alu_ctrl;
  logic             halted;
  logic             trap;
  logic [1:0]       trap_cause;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, funct3, funct7, zero_flag, alu_lt, mem_ready, resume,
    output adr_src, mem_req, mem_write, mem_ctrl, pc_write, ir_write,
           reg_write, out_mux_sel, load_extend_sel, imm_extend_sel,
           alu_src_a_sel, alu_src_b_sel, alu_ctrl, halted, trap,
           trap_cause, instret
  );

  modport slave (
    output opcode, funct3, funct7, zero_flag, alu_lt, mem_ready, resume,
    input  adr_src, mem_req, mem_write, mem_ctrl, pc_write, ir_write,
           reg_write, out_mux_sel, load_extend_sel, imm_extend_sel,
           alu_src_a_sel, alu_src_b_sel, alu_ctrl, halted, trap,
           trap_cause, instret
  );
endinterface

// File: rtl/controller_mc.sv
// -----------------------------------------------------------------------------
// controller_mc
// Multicycle control FSM for the RV32I core: fetch/decode/execute sequencing,
// variable-latency memory handshake with timeout, HALT state, illegal
// instruction and bus-timeout traps, retired-instruction counter.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - controller_mc_if.master: IR fields and flags in, datapath
//           selects/enables, status and instret out
// Outputs are decoded from the state and IR fields; only ir_write/pc_write in
// FETCH and pc_write in BRANCH look at mem_ready / ALU flags combinationally.
// While rst_n is low every output is forced to its reset value.
// -----------------------------------------------------------------------------
module controller_mc #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32,
  parameter logic [6:0]  HALT_OPCODE = 7'b1111111
) (
  input  logic             clk,
  input  logic             rst_n,
  controller_mc_if.master  bus
);

  // Opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // ALU operations
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;
  localparam logic [3:0] ALU_OR   = 4'h4;
  localparam logic [3:0] ALU_AND  = 4'h5;
  localparam logic [3:0] ALU_SLL  = 4'h6;
  localparam logic [3:0] ALU_SRL  = 4'h7;
  localparam logic [3:0] ALU_SRA  = 4'h8;
  localparam logic [3:0] ALU_SLT  = 4'h9;
  localparam logic [3:0] ALU_SLTU = 4'hA;

  // Immediate formats
  localparam logic [2:0] IMM_ZERO = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd3;
  localparam logic [2:0] IMM_B    = 3'd4;
  localparam logic [2:0] IMM_U    = 3'd5;
  localparam logic [2:0] IMM_J    = 3'd6;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  // Timeout counter: a zero MEM_TIMEOUT disables it, keep one bit anyway.
  localparam bit             TO_EN  = (MEM_TIMEOUT > 0);
  localparam int             TW     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]  TO_VAL = TW'(MEM_TIMEOUT);

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM_ADR, S_MEM_RD, S_MEM_WR, S_WB_LOAD,
    S_BRANCH, S_JAL, S_JAL2, S_JALR, S_JALR2, S_LUI, S_AUIPC, S_RETIRE,
    S_HALT, S_TRAP
  } state_t;

  state_t            state_reg, state_next;
  logic [TW-1:0]     wait_cnt_reg;
  logic [1:0]        trap_cause_reg, trap_cause_next;
  logic [CNT_W-1:0]  instret_reg;

  // ---------------------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------------------
  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
  logic is_auipc, is_halt, known_op, funct7_ok, illegal;

  always_comb begin
    is_r      = (bus.opcode == OP_R);
    is_i      = (bus.opcode == OP_I);
    is_load   = (bus.opcode == OP_LOAD);
    is_store  = (bus.opcode == OP_STORE);
    is_branch = (bus.opcode == OP_BRANCH);
    is_jal    = (bus.opcode == OP_JAL);
    is_jalr   = (bus.opcode == OP_JALR);
    is_lui    = (bus.opcode == OP_LUI);
    is_auipc  = (bus.opcode == OP_AUIPC);
    is_halt   = (bus.opcode == HALT_OPCODE);
    known_op  = is_r | is_i | is_load | is_store | is_branch | is_jal |
                is_jalr | is_lui | is_auipc;
    funct7_ok = (bus.funct7 == 7'h00) || (bus.funct7 == 7'h20);
    // All illegal encodings are caught in DECODE so no partial side effect
    // (register write, memory request) ever happens for them.
    illegal   = !known_op
              || (is_load   && (bus.funct3 == 3'd3 || bus.funct3 == 3'd6 || bus.funct3 == 3'd7))
              || (is_branch && (bus.funct3 == 3'd2 || bus.funct3 == 3'd3))
              || (is_r      && !funct7_ok)
              || (is_i      && (bus.funct3 == 3'd1 || bus.funct3 == 3'd5) && !funct7_ok);
  end

  // ALU function for R/I arithmetic. funct7=0x20 selects SUB only for R-type
  // (for ADDI those bits are immediate) and SRA for both shift forms.
  logic [3:0] arith_alu;
  always_comb begin
    arith_alu = ALU_ADD;
    unique case (bus.funct3)
      3'd0: arith_alu = (is_r && bus.funct7 == 7'h20) ? ALU_SUB : ALU_ADD;
      3'd1: arith_alu = ALU_SLL;
      3'd2: arith_alu = ALU_SLT;
      3'd3: arith_alu = ALU_SLTU;
      3'd4: arith_alu = ALU_XOR;
      3'd5: arith_alu = (bus.funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
      3'd6: arith_alu = ALU_OR;
      3'd7: arith_alu = ALU_AND;
      default: arith_alu = ALU_ADD;
    endcase
  end

  // Branch compare op and outcome. funct3[0] inverts the sense.
  logic [3:0] branch_alu;
  logic       branch_taken;
  always_comb begin
    branch_alu = ALU_SUB;
    if (bus.funct3[2])
      branch_alu = bus.funct3[1] ? ALU_SLTU : ALU_SLT;
    branch_taken = (bus.funct3[2] ? bus.alu_lt : bus.zero_flag) ^ bus.funct3[0];
  end

  // Immediate used by DECODE for the oldPC+imm target computation.
  logic [2:0] decode_imm;
  always_comb begin
    decode_imm = IMM_ZERO;
    if (is_branch)                          decode_imm = IMM_B;
    else if (is_jal)                        decode_imm = IMM_J;
    else if (is_store)                      decode_imm = IMM_S;
    else if (is_lui || is_auipc)            decode_imm = IMM_U;
    else if (is_i || is_load || is_jalr)    decode_imm = IMM_I;
  end

  // ---------------------------------------------------------------------------
  // Memory wait tracking
  // ---------------------------------------------------------------------------
  logic wait_state, timeout_hit;
  always_comb begin
    wait_state  = (state_reg == S_FETCH) || (state_reg == S_MEM_RD) ||
                  (state_reg == S_MEM_WR);
    timeout_hit = TO_EN && wait_state && (wait_cnt_reg == TO_VAL);
  end

  // ---------------------------------------------------------------------------
  // State register and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_FETCH;
      wait_cnt_reg   <= '0;
      trap_cause_reg <= CAUSE_NONE;
      instret_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      trap_cause_reg <= trap_cause_next;
      // Any state change clears the counter, so it starts at zero on entry
      // to every wait state.
      if (state_next != state_reg)
        wait_cnt_reg <= '0;
      else if (TO_EN && wait_state && !bus.mem_ready)
        wait_cnt_reg <= wait_cnt_reg + TW'(1);
      if (state_reg == S_RETIRE)
        instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    trap_cause_next = trap_cause_reg;
    unique case (state_reg)
      S_FETCH: begin
        // mem_ready wins over a coincident timeout
        if (bus.mem_ready)   state_next = S_DECODE;
        else if (timeout_hit) begin
          state_next      = S_TRAP;
          trap_cause_next = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (is_halt)                    state_next = S_HALT;
        else if (illegal) begin
          state_next      = S_TRAP;
          trap_cause_next = CAUSE_ILLEGAL;
        end
        else if (is_r || is_i)          state_next = S_EXEC;
        else if (is_load || is_store)   state_next = S_MEM_ADR;
        else if (is_branch)             state_next = S_BRANCH;
        else if (is_jal)                state_next = S_JAL;
        else if (is_jalr)               state_next = S_JALR;
        else if (is_lui)                state_next = S_LUI;
        else                            state_next = S_AUIPC;
      end
      S_EXEC:    state_next = S_RETIRE;
      S_MEM_ADR: state_next = is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD, S_MEM_WR: begin
        if (bus.mem_ready)
          state_next = (state_reg == S_MEM_RD) ? S_WB_LOAD : S_RETIRE;
        else if (timeout_hit) begin
          state_next      = S_TRAP;
          trap_cause_next = CAUSE_TIMEOUT;
        end
      end
      S_WB_LOAD: state_next = S_RETIRE;
      S_BRANCH:  state_next = S_RETIRE;
      S_JAL:     state_next = S_JAL2;
      S_JAL2:    state_next = S_RETIRE;
      S_JALR:    state_next = S_JALR2;
      S_JALR2:   state_next = S_RETIRE;
      S_LUI:     state_next = S_RETIRE;
      S_AUIPC:   state_next = S_RETIRE;
      S_RETIRE:  state_next = S_FETCH;
      S_HALT: begin
        if (bus.resume) state_next = S_FETCH;
      end
      S_TRAP: begin
        if (bus.resume) begin
          state_next      = S_FETCH;
          trap_cause_next = CAUSE_NONE;
        end
      end
      default:   state_next = S_FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.adr_src         = 1'b0;
    bus.mem_req         = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_ctrl        = 2'd2;
    bus.pc_write        = 1'b0;
    bus.ir_write        = 1'b0;
    bus.reg_write       = 1'b0;
    bus.out_mux_sel     = 2'd1;
    bus.load_extend_sel = 3'd2;
    bus.imm_extend_sel  = IMM_ZERO;
    bus.alu_src_a_sel   = 2'd0;
    bus.alu_src_b_sel   = 2'd2;
    bus.alu_ctrl        = ALU_ADD;
    bus.halted          = 1'b0;
    bus.trap            = 1'b0;
    // Holding everything at defaults during reset keeps a request that was
    // in flight from leaking out while the FSM is already forced to FETCH.
    if (rst_n) begin
      unique case (state_reg)
        S_FETCH: begin
          // PC+4 with the default selects; the request drops on the
          // timeout cycle
          bus.mem_req  = !timeout_hit;
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_a_sel  = 2'd1;
          bus.alu_src_b_sel  = 2'd1;
          bus.imm_extend_sel = decode_imm;
        end
        S_EXEC: begin
          bus.alu_src_a_sel  = 2'd2;
          bus.alu_src_b_sel  = is_r ? 2'd0 : 2'd1;
          bus.imm_extend_sel = is_r ? IMM_ZERO : IMM_I;
          bus.alu_ctrl       = arith_alu;
          bus.reg_write      = 1'b1;
        end
        S_MEM_ADR: begin
          bus.alu_src_a_sel  = 2'd2;
          bus.alu_src_b_sel  = 2'd1;
          bus.imm_extend_sel = is_store ? IMM_S : IMM_I;
        end
        S_MEM_RD, S_MEM_WR: begin
          bus.adr_src   = 1'b1;
          bus.mem_req   = !timeout_hit;
          bus.mem_write = (state_reg == S_MEM_WR) && !timeout_hit;
          bus.mem_ctrl  = bus.funct3[1:0];
        end
        S_WB_LOAD: begin
          bus.out_mux_sel = 2'd2;
          bus.reg_write   = 1'b1;
          unique case (bus.funct3)
            3'd0:    bus.load_extend_sel = 3'd0;
            3'd1:    bus.load_extend_sel = 3'd1;
            3'd4:    bus.load_extend_sel = 3'd3;
            3'd5:    bus.load_extend_sel = 3'd4;
            default: bus.load_extend_sel = 3'd2;
          endcase
        end
        S_BRANCH: begin
          bus.alu_src_a_sel = 2'd2;
          bus.alu_src_b_sel = 2'd0;
          bus.alu_ctrl      = branch_alu;
          bus.out_mux_sel   = 2'd0;   // target latched in DECODE
          bus.pc_write      = branch_taken;
        end
        S_JAL, S_JALR: begin
          // link value: PC + 0
          bus.alu_src_b_sel = 2'd1;
          bus.reg_write     = 1'b1;
        end
        S_JAL2: begin
          bus.out_mux_sel = 2'd0;
          bus.pc_write    = 1'b1;
        end
        S_JALR2: begin
          bus.alu_src_a_sel  = 2'd2;
          bus.alu_src_b_sel  = 2'd1;
          bus.imm_extend_sel = IMM_I;
          bus.pc_write       = 1'b1;
        end
        S_LUI: begin
          bus.alu_src_a_sel  = 2'd3;
          bus.alu_src_b_sel  = 2'd1;
          bus.imm_extend_sel = IMM_U;
          bus.reg_write      = 1'b1;
        end
        S_AUIPC: begin
          bus.alu_src_a_sel  = 2'd1;
          bus.alu_src_b_sel  = 2'd1;
          bus.imm_extend_sel = IMM_U;
          bus.reg_write      = 1'b1;
        end
        S_HALT:  bus.halted = 1'b1;
        S_TRAP:  bus.trap   = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.trap_cause = trap_cause_reg;
    bus.instret    = instret_reg;
  end

endmodule

// File: tb/tb_controller_mc.sv
// -----------------------------------------------------------------------------
// tb_controller_mc
// Instruction-level bench for controller_mc: each instruction is expanded
// into the sequence of control words it should produce, from the ISA rules,
// and compared cycle by cycle. Memory latency, flags and fields are random.
// -----------------------------------------------------------------------------
module tb_controller_mc;
  localparam int TO = 4;
  localparam int CW = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  controller_mc_if #(.CNT_W(CW)) bus();

  controller_mc #(.MEM_TIMEOUT(TO), .CNT_W(CW), .HALT_OPCODE(OP_HALT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       adr_src, mem_req, mem_write;
    logic [1:0] mem_ctrl;
    logic       pc_write, ir_write, reg_write;
    logic [1:0] out_mux;
    logic [2:0] load_ext, imm;
    logic [1:0] a, b;
    logic [3:0] alu;
    logic       halted, trap;
    logic [1:0] cause;
  } ctl_t;

  int n_vec = 0;
  int n_err = 0;
  int exp_instret = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ctl_t ctl_idle();
    ctl_t c = '0;
    c.mem_ctrl = 2'd2; c.out_mux = 2'd1; c.load_ext = 3'd2;
    c.b = 2'd2; c.alu = 4'h1;
    return c;
  endfunction

  function automatic ctl_t observed();
    ctl_t c;
    c.adr_src = bus.adr_src;   c.mem_req = bus.mem_req;   c.mem_write = bus.mem_write;
    c.mem_ctrl = bus.mem_ctrl; c.pc_write = bus.pc_write; c.ir_write = bus.ir_write;
    c.reg_write = bus.reg_write; c.out_mux = bus.out_mux_sel;
    c.load_ext = bus.load_extend_sel; c.imm = bus.imm_extend_sel;
    c.a = bus.alu_src_a_sel; c.b = bus.alu_src_b_sel; c.alu = bus.alu_ctrl;
    c.halted = bus.halted; c.trap = bus.trap; c.cause = bus.trap_cause;
    return c;
  endfunction

  // Inputs are already driven (posedge+1); sample on the falling edge.
  task automatic step(input string tag, input ctl_t e);
    @(negedge clk);
    check_val(tag, {4'b0, observed()}, {4'b0, e});
    $display("cycle %-8s op=%b f3=%0d ctl=%h", tag, bus.opcode, bus.funct3, observed());
    @(posedge clk); #1;
  endtask

  // ---------------- reference rules -----------------------------------------
  function automatic bit legal(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bit f7ok = (f7 == 7'h00) || (f7 == 7'h20);
    case (op)
      OP_R:      return f7ok;
      OP_I:      return (f3 == 3'd1 || f3 == 3'd5) ? f7ok : 1'b1;
      OP_LOAD:   return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      OP_BRANCH: return !(f3 == 3'd2 || f3 == 3'd3);
      OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] imm_dec(input logic [6:0] op);
    case (op)
      OP_BRANCH:                 return 3'd4;
      OP_JAL:                    return 3'd6;
      OP_STORE:                  return 3'd3;
      OP_LUI, OP_AUIPC:          return 3'd5;
      OP_I, OP_LOAD, OP_JALR:    return 3'd1;
      default:                   return 3'd0;
    endcase
  endfunction

  function automatic logic [3:0] arith_alu(input bit r, input logic [2:0] f3, input logic [6:0] f7);
    case (f3)
      3'd0: return (r && f7 == 7'h20) ? 4'h2 : 4'h1;
      3'd1: return 4'h6;
      3'd2: return 4'h9;
      3'd3: return 4'hA;
      3'd4: return 4'h3;
      3'd5: return (f7 == 7'h20) ? 4'h8 : 4'h7;
      3'd6: return 4'h4;
      default: return 4'h5;
    endcase
  endfunction

  function automatic logic [3:0] br_alu(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd1: return 4'h2;
      3'd4, 3'd5: return 4'h9;
      default:    return 4'hA;
    endcase
  endfunction

  function automatic bit br_taken(input logic [2:0] f3, input bit zf, input bit lt);
    case (f3)
      3'd0: return zf;
      3'd1: return !zf;
      3'd4, 3'd6: return lt;
      default: return !lt;
    endcase
  endfunction

  function automatic logic [2:0] ld_ext(input logic [2:0] f3);
    case (f3)
      3'd0: return 3'd0;
      3'd1: return 3'd1;
      3'd4: return 3'd3;
      3'd5: return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

  function automatic int pick_wait();
    if ($urandom_range(0, 9) < 7) return int'($urandom_range(0, 2));
    return int'($urandom_range(3, TO + 1));
  endfunction

  // ---------------- sequences ----------------------------------------------
  // A request lasts until mem_ready (after w waits) or until TO waits have
  // passed; on the TO-th cycle the request is withdrawn but a ready that
  // arrives then still completes.
  task automatic mem_phase(input string tag, input ctl_t base, input bit is_fetch,
                           input int w, output bit ok);
    ctl_t e;
    ok = 1'b0;
    for (int k = 0; k <= TO; k++) begin
      e = base;
      bus.mem_ready = (k == w);
      e.mem_req = (k < TO);
      if (k == TO) e.mem_write = 1'b0;
      if (is_fetch && k == w) begin e.ir_write = 1'b1; e.pc_write = 1'b1; end
      step(tag, e);
      if (k == w) begin ok = 1'b1; break; end
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic park(input string tag, input ctl_t e);
    int n;
    n = int'($urandom_range(0, 2));
    for (int i = 0; i < n; i++) step(tag, e);
    bus.resume = 1'b1;
    step(tag, e);
    bus.resume = 1'b0;
  endtask

  task automatic run_trap(input logic [1:0] cause);
    ctl_t e = ctl_idle();
    e.trap = 1'b1; e.cause = cause;
    park("trap", e);
  endtask

  task automatic exec_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input bit zf, input bit lt, input int fw_in, input int mw_in);
    ctl_t e;
    bit ok;
    int fw, mw;
    fw = (fw_in < 0) ? pick_wait() : fw_in;
    mw = (mw_in < 0) ? pick_wait() : mw_in;
    bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
    bus.zero_flag = zf; bus.alu_lt = lt;
    check_val("instret", 32'(bus.instret), 32'(exp_instret % (1 << CW)));

    mem_phase("fetch", ctl_idle(), 1'b1, fw, ok);
    if (!ok) begin run_trap(2'd2); return; end

    e = ctl_idle(); e.a = 2'd1; e.b = 2'd1; e.imm = imm_dec(op);
    step("decode", e);

    if (op == OP_HALT) begin
      e = ctl_idle(); e.halted = 1'b1;
      park("halt", e);
      return;
    end
    if (!legal(op, f3, f7)) begin run_trap(2'd1); return; end

    e = ctl_idle();
    case (op)
      OP_R, OP_I: begin
        e.a = 2'd2; e.b = (op == OP_R) ? 2'd0 : 2'd1; e.imm = (op == OP_R) ? 3'd0 : 3'd1;
        e.alu = arith_alu(op == OP_R, f3, f7); e.reg_write = 1'b1;
        step("exec", e);
      end
      OP_LOAD, OP_STORE: begin
        e.a = 2'd2; e.b = 2'd1; e.imm = (op == OP_STORE) ? 3'd3 : 3'd1;
        step("mem_adr", e);
        e = ctl_idle(); e.adr_src = 1'b1; e.mem_ctrl = f3[1:0];
        e.mem_write = (op == OP_STORE);
        mem_phase("mem", e, 1'b0, mw, ok);
        if (!ok) begin run_trap(2'd2); return; end
        if (op == OP_LOAD) begin
          e = ctl_idle(); e.out_mux = 2'd2; e.load_ext = ld_ext(f3); e.reg_write = 1'b1;
          step("wb_load", e);
        end
      end
      OP_BRANCH: begin
        e.a = 2'd2; e.b = 2'd0; e.alu = br_alu(f3); e.out_mux = 2'd0;
        e.pc_write = br_taken(f3, zf, lt);
        step("branch", e);
      end
      OP_JAL, OP_JALR: begin
        e.b = 2'd1; e.reg_write = 1'b1;
        step("link", e);
        e = ctl_idle(); e.pc_write = 1'b1;
        if (op == OP_JAL) e.out_mux = 2'd0;
        else begin e.a = 2'd2; e.b = 2'd1; e.imm = 3'd1; end
        step("jump", e);
      end
      default: begin  // LUI / AUIPC
        e.a = (op == OP_LUI) ? 2'd3 : 2'd1; e.b = 2'd1; e.imm = 3'd5; e.reg_write = 1'b1;
        step("upper", e);
      end
    endcase
    step("retire", ctl_idle());
    exp_instret++;
  endtask

  task automatic reset_mid_load();
    ctl_t e;
    bit ok;
    bus.opcode = OP_LOAD; bus.funct3 = 3'd2; bus.funct7 = 7'd0;
    mem_phase("fetch", ctl_idle(), 1'b1, 0, ok);
    e = ctl_idle(); e.a = 2'd1; e.b = 2'd1; e.imm = 3'd1;
    step("decode", e);
    e = ctl_idle(); e.a = 2'd2; e.b = 2'd1; e.imm = 3'd1;
    step("mem_adr", e);
    bus.mem_ready = 1'b0;
    #2;
    check_val("memrd_req", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rst_ctl", {4'b0, observed()}, {4'b0, ctl_idle()});
    check_val("rst_instret", 32'(bus.instret), 32'd0);
    $display("reset asserted mid MEM_RD ctl=%h instret=%0d", observed(), bus.instret);
    exp_instret = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  initial begin
    logic [6:0] ops [11];
    logic [6:0] op, f7;
    logic [2:0] f3;
    int sel;
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
            OP_LUI, OP_AUIPC, OP_HALT, 7'b0001011};
    rst_n = 1'b0;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7 = '0;
    bus.zero_flag = 1'b0; bus.alu_lt = 1'b0; bus.mem_ready = 1'b0; bus.resume = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_ctl", {4'b0, observed()}, {4'b0, ctl_idle()});
    check_val("reset_instret", 32'(bus.instret), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // directed cases
    exec_instr(OP_R,      3'd0, 7'h00, 1'b0, 1'b0, 0, 0);   // ADD
    exec_instr(OP_LOAD,   3'd2, 7'h00, 1'b0, 1'b0, 0, 3);   // LW, 3 waits
    exec_instr(OP_BRANCH, 3'd1, 7'h00, 1'b0, 1'b0, 0, 0);   // BNE taken
    exec_instr(OP_BRANCH, 3'd1, 7'h00, 1'b1, 1'b0, 0, 0);   // BNE not taken
    exec_instr(OP_R,      3'd0, 7'h00, 1'b0, 1'b0, TO + 1, 0); // fetch timeout
    exec_instr(OP_STORE,  3'd0, 7'h00, 1'b0, 1'b0, 1, TO);  // ready on timeout cycle
    exec_instr(7'b0001011, 3'd0, 7'h00, 1'b0, 1'b0, 0, 0);  // illegal opcode
    exec_instr(OP_HALT,   3'd0, 7'h00, 1'b0, 1'b0, 0, 0);   // HALT
    exec_instr(OP_R,      3'd5, 7'h10, 1'b0, 1'b0, 0, 0);   // bad funct7
    exec_instr(OP_JALR,   3'd0, 7'h00, 1'b0, 1'b0, 0, 0);
    reset_mid_load();
    exec_instr(OP_R,      3'd0, 7'h20, 1'b0, 1'b0, 0, 0);   // SUB after reset

    // random instruction stream (instret wraps at 16)
    for (int n = 0; n < 120; n++) begin
      sel = int'($urandom_range(0, 10));
      op  = ops[sel];
      f3  = 3'($urandom_range(0, 7));
      if (op == OP_STORE) f3 = 3'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0, 1: f7 = 7'h00;
        2:    f7 = 7'h20;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      exec_instr(op, f3, f7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
    end
    check_val("final_instret", 32'(bus.instret), 32'(exp_instret % (1 << CW)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/controller_mc.md
Name: controller_mc

Overview:
Parametrised multicycle control FSM for the RV32I core. It is the successor of the current main controller. New capabilities:
- variable-latency memory req/ready handshake with a timeout;
- full RV32I control flow (JAL, JALR, LUI, AUIPC, branches) with explicit per-instruction states;
- HALT state, illegal-instruction and bus-error traps;
- retired-instruction counter.

It drives the same datapath mux/ALU selects as today.

Parameters:
MEM_TIMEOUT, 16, cycles waiting on mem_ready before bus-error trap; 0 disables the timeout.
CNT_W, 32, width of the instret counter.
HALT_OPCODE, 7'b1111111, opcode that enters HALT.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero_flag  in  1  ALU result == 0
- alu_lt  in  1  ALU compare less-than
- mem_ready  in  1  memory completes current request this cycle
- resume  in  1  leave HALT/TRAP
- adr_src  out  1  0=PC, 1=ALU result register
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a store
- mem_ctrl  out  2  0=byte, 1=half, 2=word
- pc_write  out  1  PC load enable
- ir_write  out  1  IR load enable
- reg_write  out  1  regfile write enable
- out_mux_sel  out  2  0=ALU result reg, 1=ALU direct, 2=load data
- load_extend_sel  out  3  0=LB, 1=LH, 2=LW, 3=LBU, 4=LHU
- imm_extend_sel  out  3  0=zero, 1=I, 3=S, 4=B, 5=U, 6=J
- alu_src_a_sel  out  2  0=PC, 1=oldPC, 2=rs1, 3=zero
- alu_src_b_sel  out  2  0=rs2, 1=imm, 2=const 4
- alu_ctrl  out  4  1 add, 2 sub, 3 xor, 4 or, 5 and, 6 sll, 7 srl, 8 sra, 9 slt, A sltu
- halted  out  1  FSM in HALT
- trap  out  1  FSM in TRAP
- trap_cause  out  2  0=none, 1=illegal opcode/funct, 2=bus timeout
- instret  out  CNT_W  retired-instruction count

Behaviour:
Outputs are Moore, decoded from state plus IR fields only. They never depend combinationally on mem_ready, except ir_write and pc_write in FETCH and the branch pc_write.

Reset (rst_n low, asynchronous):
- state=FETCH.
- instret=0, trap_cause=0.
- All enables=0.
- Selects at defaults: adr_src 0, a=0, b=2, alu_ctrl 1, out_mux 1, imm 0, mem_ctrl 2, load_ext 2.

FETCH:
- mem_req=1, adr_src=0, ALU computes PC+4 (a=0, b=2, add).
- On mem_ready: ir_write=1, pc_write=1 (PC<=PC+4; oldPC latched by datapath) -> DECODE.

DECODE:
- ALU computes oldPC+imm with imm per opcode, for branch/jump targets.
- Dispatch:
  - R/I-arith -> EXEC
  - load/store -> MEM_ADR
  - branch -> BRANCH
  - JAL -> JAL
  - JALR -> JALR
  - LUI -> LUI
  - AUIPC -> AUIPC
  - HALT_OPCODE -> HALT
  - anything else -> TRAP, cause 1.

EXEC:
- a=2; b=0 (R) or 1 (I).
- funct decode: SUB/SRA require funct7=0x20; SLTI funct3=2, SLTIU funct3=3.
- Shift-immediate with funct7 not in {0x00, 0x20}, and R-type with funct7 not in {0x00, 0x20}, -> TRAP cause 1.
- reg_write=1, out_mux=1 -> RETIRE.

MEM_ADR:
- a=2, b=1, imm I (load) or S (store), add; ALU result register latches.
- -> MEM_RD or MEM_WR.

MEM_RD / MEM_WR:
- adr_src=1, mem_req=1, mem_write=1 in MEM_WR only.
- mem_ctrl from funct3[1:0].
- Hold in state until mem_ready, then:
  - MEM_RD -> WB_LOAD.
  - MEM_WR -> RETIRE.

WB_LOAD: out_mux=2, load_extend_sel from funct3, reg_write=1 -> RETIRE. Load funct3 in {3,6,7} is illegal and traps in DECODE.

BRANCH:
- a=2, b=0; alu_ctrl sub (BEQ/BNE), slt (BLT/BGE), sltu (BLTU/BGEU).
- Condition true: pc_write=1, out_mux=0 (target from DECODE).
- -> RETIRE. funct3 in {2,3} traps in DECODE.

JAL:
- Cycle 1: reg_write=1, rd<=PC (a=0, b=imm zero-sel, add).
- Cycle 2 (JAL2): pc_write=1 with out_mux=0.
- -> RETIRE.

JALR:
- Cycle 1: rd<=PC as above.
- Cycle 2: a=2, b=1, imm I, add, out_mux=1, pc_write=1.
- Target LSB is cleared in the datapath.

LUI: a=3, b=1, imm U, reg_write -> RETIRE.
AUIPC: a=1, b=1, imm U, reg_write -> RETIRE.

RETIRE: instret<=instret+1, wraps at 2^CNT_W -> FETCH.

Timeout:
- A cycle counter ($clog2(MEM_TIMEOUT+1) bits) clears on entering FETCH/MEM_RD/MEM_WR and counts each waiting cycle.
- Reaching MEM_TIMEOUT without mem_ready -> TRAP cause 2; mem_req drops that cycle.
- mem_ready arriving in the same cycle as the timeout counts as success.

HALT / TRAP:
- All enables 0; halted or trap held.
- resume -> FETCH and clears trap_cause.
- HALT does not increment instret.

Writes to rd=x0 are not suppressed here; the regfile handles them.

Test Plan:
- Reset mid-MEM_RD with mem_req high -> all outputs at reset values in the same cycle; instret=0; next state FETCH.
- ADD x3,x1,x2 with mem_ready tied 1 -> 4 cycles FETCH, DECODE, EXEC, RETIRE; reg_write in EXEC with alu_ctrl=1; instret 0->1.
- LW with mem_ready asserted after 3 wait cycles (MEM_TIMEOUT=16) -> mem_req held 4 cycles in MEM_RD, adr_src=1; WB_LOAD with out_mux=2, load_extend_sel=2.
- BNE, zero_flag=0 -> pc_write=1 in BRANCH. Repeat with zero_flag=1 -> pc_write=0 throughout BRANCH.
- Fetch with mem_ready never asserted, MEM_TIMEOUT=4 -> TRAP after 4 wait cycles, trap_cause=2. resume -> FETCH, trap_cause=0.
- Opcode 7'b0001011 -> TRAP cause 1. Opcode 7'b1111111 -> halted=1, instret unchanged; resume -> FETCH.
